// File: rtl/clock_step_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state encoding and divisor limits.
package clock_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_DIV = 5;
  localparam int unsigned MIN_DIV     = 2;

endpackage

// File: rtl/clock_step_ctrl_period_counter.sv
// Programmable mod-div period counter; the divisor only changes when load is asserted,
// so the owner decides when a new divisor may take effect.
module period_counter #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RESET_DIV = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic [CNT_W-1:0] div
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q;

  always_comb begin
    last  = en && (cnt_q == div_q - CNT_W'(1));
    cnt_d = (en && !last) ? cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= CNT_W'(RESET_DIV);
    end else begin
      cnt_q <= cnt_d;
      if (load) div_q <= div_in;
    end
  end

  assign cnt = cnt_q;
  assign div = div_q;

endmodule

// File: rtl/clock_step_ctrl.sv
// Run-control sequencer for the processor clock divider: gates the divided clock and tick
// by run/step/burst/halt requests and applies divisor changes only at period boundaries.
module clock_step_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = clock_step_ctrl_pkg::DEFAULT_DIV,
  parameter int unsigned BURST_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cpu_halt,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_value,
  output logic               clock,
  output logic               tick,
  output logic               div_ack,
  output logic               div_err,
  output logic [1:0]         state,
  output logic [BURST_W-1:0] ticks_left
);

  import clock_step_ctrl_pkg::*;

  state_e             state_q, state_d;
  logic [BURST_W-1:0] ticks_q, ticks_d;
  logic               halt_pend_q, halt_pend_d;
  logic               pend_v_q, pend_v_d;
  logic [CNT_W-1:0]   pend_val_q, pend_val_d;
  logic               clock_q, clock_d;
  logic               tick_q, tick_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  logic               active_c, last_c, load_c, div_ok_c, go_halt_c;
  logic [CNT_W-1:0]   cnt_c, div_c, div_in_c, cnt_nxt_c, div_nxt_c;

  period_counter #(
    .CNT_W     (CNT_W),
    .RESET_DIV (DEFAULT_DIV)
  ) u_period_counter (
    .clk    (clk),
    .reset  (reset),
    .en     (active_c),
    .div_in (div_in_c),
    .load   (load_c),
    .cnt    (cnt_c),
    .last   (last_c),
    .div    (div_c)
  );

  always_comb begin
    state_d     = state_q;
    ticks_d     = ticks_q;
    halt_pend_d = halt_pend_q;
    pend_v_d    = pend_v_q;
    pend_val_d  = pend_val_q;
    load_c      = 1'b0;
    div_in_c    = div_value;
    go_halt_c   = 1'b0;
    active_c    = (state_q != ST_HALT);
    div_ok_c    = (div_value >= CNT_W'(MIN_DIV));
    err_d       = div_load && !div_ok_c;

    // Divisor: immediate in HALT, otherwise held pending until the boundary.
    if (!active_c) begin
      load_c = div_load && div_ok_c;
    end else if (last_c) begin
      pend_v_d = 1'b0;
      if (div_load && div_ok_c) begin
        load_c = 1'b1;
      end else if (pend_v_q) begin
        load_c   = 1'b1;
        div_in_c = pend_val_q;
      end
    end else if (div_load && div_ok_c) begin
      pend_v_d   = 1'b1;
      pend_val_d = div_value;
    end
    ack_d = load_c;

    unique case (state_q)
      ST_HALT: begin
        halt_pend_d = 1'b0;
        if (!cpu_halt) begin
          if (run_req) begin
            state_d = ST_RUN;
          end else if (burst_req && (burst_len != '0)) begin
            state_d = ST_BURST;
            ticks_d = burst_len;
          end else if (step_req) begin
            state_d = ST_STEP;
          end
        end
      end
      ST_RUN:  go_halt_c = !run_req;
      ST_STEP: go_halt_c = 1'b1;
      ST_BURST: begin
        if (last_c) ticks_d = ticks_q - BURST_W'(1);
        go_halt_c = (ticks_q == BURST_W'(1));
      end
      default: state_d = ST_HALT;
    endcase

    // Active periods always run to their boundary; a halt request only lands there.
    if (active_c) begin
      if (last_c) begin
        halt_pend_d = 1'b0;
        if (go_halt_c || halt_pend_q || cpu_halt) begin
          state_d = ST_HALT;
          ticks_d = '0;
        end
      end else begin
        halt_pend_d = halt_pend_q | cpu_halt;
      end
    end

    cnt_nxt_c = (active_c && !last_c) ? cnt_c + CNT_W'(1) : '0;
    div_nxt_c = load_c ? div_in_c : div_c;
    clock_d   = (state_d != ST_HALT) && (cnt_nxt_c < (div_nxt_c >> 1));
    tick_d    = (state_d != ST_HALT) && (cnt_nxt_c == div_nxt_c - CNT_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HALT;
      ticks_q     <= '0;
      halt_pend_q <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_val_q  <= '0;
      clock_q     <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ticks_q     <= ticks_d;
      halt_pend_q <= halt_pend_d;
      pend_v_q    <= pend_v_d;
      pend_val_q  <= pend_val_d;
      clock_q     <= clock_d;
      tick_q      <= tick_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign clock      = clock_q;
  assign tick       = tick_q;
  assign div_ack    = ack_q;
  assign div_err    = err_q;
  assign state      = state_q;
  assign ticks_left = ticks_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Scoreboard bench for clock_step_ctrl: a period-level reference model queues the expected
// outputs of every cycle, a negedge monitor compares them; directed windows add absolute checks.
module tb_clock_step_ctrl;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BURST_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               run_req, step_req, burst_req, cpu_halt, div_load;
  logic [BURST_W-1:0] burst_len;
  logic [CNT_W-1:0]   div_value;
  logic               clock, tick, div_ack, div_err;
  logic [1:0]         state;
  logic [BURST_W-1:0] ticks_left;

  clock_step_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (5),
    .BURST_W     (BURST_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run_req    (run_req),
    .step_req   (step_req),
    .burst_req  (burst_req),
    .burst_len  (burst_len),
    .cpu_halt   (cpu_halt),
    .div_load   (div_load),
    .div_value  (div_value),
    .clock      (clock),
    .tick       (tick),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .state      (state),
    .ticks_left (ticks_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               clock;
    logic               tick;
    logic               ack;
    logic               err;
    logic [1:0]         st;
    logic [BURST_W-1:0] left;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0 halt, 1 run, 2 step, 3 burst; pos is the position inside the period.
  int m_mode, m_pos, m_div, m_pend, m_left;
  bit m_hp, m_ack, m_err;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_div = 5; m_pend = 0; m_left = 0;
    m_hp = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit active, bnd, valid, go_halt;
    active = (m_mode != 0);
    bnd    = active && (m_pos == m_div - 1);
    valid  = div_load && (div_value >= 2);
    m_err  = div_load && (div_value < 2);
    m_ack  = 0;
    if (!active) begin
      if (valid) begin m_div = int'(div_value); m_ack = 1; end
    end else if (bnd) begin
      if (valid) begin m_div = int'(div_value); m_ack = 1; end
      else if (m_pend != 0) begin m_div = m_pend; m_ack = 1; end
      m_pend = 0;
    end else if (valid) begin
      m_pend = int'(div_value);
    end
    if (!active) begin
      if (cpu_halt) m_mode = 0;
      else if (run_req) m_mode = 1;
      else if (burst_req && burst_len != 0) begin m_mode = 3; m_left = int'(burst_len); end
      else if (step_req) m_mode = 2;
    end else if (bnd) begin
      go_halt = m_hp || cpu_halt;
      if (m_mode == 1 && !run_req) go_halt = 1;
      if (m_mode == 2) go_halt = 1;
      if (m_mode == 3) begin
        m_left = m_left - 1;
        if (m_left == 0) go_halt = 1;
      end
      if (go_halt) begin m_mode = 0; m_left = 0; end
      m_hp  = 0;
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
      if (cpu_halt) m_hp = 1;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (reset) model_reset();
    else       model_step();
    e.clock = (m_mode != 0) && (m_pos < m_div / 2);
    e.tick  = (m_mode != 0) && (m_pos == m_div - 1);
    e.ack   = m_ack;
    e.err   = m_err;
    e.st    = 2'(m_mode);
    e.left  = BURST_W'(m_left);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {clock, tick, div_ack, div_err, state, ticks_left};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_cmp @%0t: got clock=%b tick=%b ack=%b err=%b state=%0d left=%0d, expected clock=%b tick=%b ack=%b err=%b state=%0d left=%0d",
                 $time, a.clock, a.tick, a.ack, a.err, a.st, a.left,
                 e.clock, e.tick, e.ack, e.err, e.st, e.left);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts ticks and clock-high cycles over n cycles, starting with the current one.
  task automatic window(string name, int n, int et, int ec);
    int t, c;
    t = 0; c = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (tick)  t++;
      if (clock) c++;
    end
    chk({name, "_ticks"}, t, et);
    chk({name, "_clock_hi"}, c, ec);
  endtask

  task automatic wait_halt(string name, int budget);
    int n;
    n = 0;
    while (state != 2'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached_halt"}, int'(state), 0);
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    run_req = 1'b0; step_req = 1'b0; burst_req = 1'b0; cpu_halt = 1'b0;
    div_load = 1'b0; burst_len = '0; div_value = '0;
    #1;
    chk("reset_outputs", int'({clock, tick, div_ack, div_err, state, ticks_left}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single step at D=5
    pulse_step();
    window("step", 10, 1, 2);
    chk("step_state", int'(state), 0);

    // Burst of three and the empty burst
    burst_req = 1'b1; burst_len = 8'd3;
    @(negedge clk);
    burst_req = 1'b0;
    chk("burst_left_start", int'(ticks_left), 3);
    window("burst3", 20, 3, 6);
    chk("burst_left_end", int'(ticks_left), 0);
    burst_req = 1'b1; burst_len = 8'd0;
    @(negedge clk);
    burst_req = 1'b0;
    window("burst0", 8, 0, 0);
    chk("burst0_state", int'(state), 0);

    // Free run with a halt instruction mid-period
    run_req = 1'b1;
    repeat (6) @(negedge clk);
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    repeat (5) @(negedge clk);
    run_req = 1'b0;
    wait_halt("run_halt", 30);
    window("halted", 5, 0, 0);

    // Divisor change while running
    run_req = 1'b1;
    repeat (2) @(negedge clk);
    div_load = 1'b1; div_value = 16'd8;
    @(negedge clk);
    div_load = 1'b0;
    repeat (30) @(negedge clk);
    run_req = 1'b0;
    wait_halt("div8_run", 30);
    pulse_step();
    window("step_d8", 12, 1, 4);

    // Rejected divisor, then two loads inside one period
    div_load = 1'b1; div_value = 16'd1;
    @(negedge clk);
    div_load = 1'b0;
    chk("div_err_pulse", int'(div_err), 1);
    run_req = 1'b1;
    @(negedge clk);
    div_load = 1'b1; div_value = 16'd6;
    @(negedge clk);
    div_value = 16'd3;
    @(negedge clk);
    div_load = 1'b0;
    repeat (20) @(negedge clk);
    run_req = 1'b0;
    wait_halt("overwrite_run", 30);
    pulse_step();
    window("step_d3", 6, 1, 1);
    div_load = 1'b1; div_value = 16'd5;
    @(negedge clk);
    div_load = 1'b0;
    @(negedge clk);

    // Asynchronous reset at cnt=2 with a divisor load still pending
    run_req = 1'b1;
    @(negedge clk);
    div_load = 1'b1; div_value = 16'd7;
    @(negedge clk);
    div_load = 1'b0;
    n = 0;
    while (!(m_mode == 1 && m_pos == 2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_cnt2", int'(m_mode == 1 && m_pos == 2), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_clock", int'(clock), 0);
    chk("async_tick", int'(tick), 0);
    run_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulse_step();
    window("step_after_reset", 10, 1, 2);

    // Randomised traffic, including occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) run_req = ~run_req;
      step_req  = ($urandom_range(0, 14) == 0);
      burst_req = ($urandom_range(0, 19) == 0);
      burst_len = BURST_W'($urandom_range(0, 4));
      cpu_halt  = ($urandom_range(0, 29) == 0);
      div_load  = ($urandom_range(0, 24) == 0);
      div_value = CNT_W'($urandom_range(0, 9));
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    run_req = 1'b0; step_req = 1'b0; burst_req = 1'b0; cpu_halt = 1'b0; div_load = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_step_ctrl.md
Name: clock_step_ctrl

Overview:
- Run-control sequencer for the processor clock divider.
- Owns a programmable divide-by-D counter and drives the divided `clock` plus a one-cycle `tick` enable.
- Gates both according to run / single-step / burst / halt requests from the bench, the front panel or the CPU's halt instruction.
- Divisor changes are synchronised to period boundaries, so the CPU never sees a runt period.

Parameters:
- CNT_W, 16, width of divisor and period counter.
- DEFAULT_DIV, 5, divisor loaded at reset; must be >= 2.
- BURST_W, 8, width of burst length and remaining-tick counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run_req  in  1  level; free-run while high.
- step_req  in  1  pulse; run exactly one divided period.
- burst_req  in  1  pulse; run burst_len periods.
- burst_len  in  BURST_W  period count, sampled with burst_req.
- cpu_halt  in  1  pulse from CPU halt instruction.
- div_load  in  1  pulse; request new divisor.
- div_value  in  CNT_W  new divisor, sampled with div_load.
- clock  out  1  divided clock, registered, glitch-free.
- tick  out  1  one clk-cycle enable, high in last cycle of each active period.
- div_ack  out  1  one-cycle pulse when a new divisor takes effect.
- div_err  out  1  one-cycle pulse when div_value < 2 is rejected.
- state  out  2  0 HALT, 1 RUN, 2 STEP, 3 BURST.
- ticks_left  out  BURST_W  remaining burst periods; 0 outside BURST.

Behaviour:
- Reset (async, immediate, also mid-period):
  - state=HALT, cnt=0, div=DEFAULT_DIV.
  - clock=0, tick=0, div_ack=0, div_err=0.
  - pending divisor and halt_pending cleared, ticks_left=0.
- Period counter `cnt` counts 0..div-1 only in RUN/STEP/BURST. In HALT it is held at 0.
- `clock` equals (active && cnt < div>>1) in every cycle.
  - D=5: high 2 cycles, low 3.
  - D=2: high 1, low 1.
- `tick` = active && cnt==div-1. A boundary is the edge that ends a cycle with tick=1.
- HALT transitions, with priority cpu_halt > run_req > burst_req > step_req:
  - cpu_halt: stay in HALT.
  - run_req: go to RUN.
  - burst_req with burst_len != 0: go to BURST, ticks_left=burst_len.
  - burst_req with burst_len==0: no-op.
  - step_req: go to STEP.
- A request sampled at edge k makes the first active cycle k+1 (cnt=0, clock=1), with tick in cycle k+div.
- RUN:
  - If run_req is low or halt_pending at a boundary, go to HALT.
  - Otherwise wrap cnt to 0 and continue.
- STEP: go to HALT at its first boundary.
- BURST:
  - Decrement ticks_left at each boundary.
  - When it reaches 0, go to HALT (ticks_left=0).
- cpu_halt while active sets halt_pending. The current period always completes with its tick, then the block goes to HALT and clears halt_pending. It never truncates a period.
- Ignored requests:
  - step_req and burst_req are ignored outside HALT.
  - run_req is ignored in STEP/BURST.
  - No queueing: after STEP/BURST ends, the block spends at least one cycle in HALT before re-evaluating.
- Divisor load:
  - div_load with div_value<2: div_err pulses in the next cycle; divisor and pending are unchanged.
  - Valid load in HALT: div updated at that edge; div_ack pulses the next cycle.
  - Valid load while active: stored as pending and applied at the next boundary, with div_ack in the cycle after that boundary.
  - A newer valid load overwrites an unapplied pending value. Only one div_ack is issued.
- Simultaneous events:
  - div_load at the boundary edge is applied at that boundary.
  - cpu_halt at the boundary edge halts at that boundary.
- There is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding localparams (ST_HALT, ST_RUN, ST_STEP, ST_BURST);
  - DEFAULT_DIV;
  - MIN_DIV=2.
- One natural sub-module: `period_counter`.
  - Role: programmable mod-div counter with enable, boundary flag and deferred divisor load.
  - Ports: clk, reset, en, div_in, load, cnt, last.
  - Rest: the state machine in the top module.

Test Plan:
- Reset, step: reset then step_req at edge k, D=5.
  - Expected: clock high in cycles k+1..k+2, low k+3..k+5; tick only in k+5; state STEP → HALT at k+6.
- Burst: burst_req with burst_len=3, D=5.
  - Expected: exactly 3 ticks 5 cycles apart; ticks_left 3→2→1→0; HALT after the third tick.
  - Repeat with burst_len=0: stays in HALT, no tick.
- Run with halt: run_req high 12 cycles, cpu_halt pulsed in cycle 7.
  - Expected: current period finishes with its tick; HALT after the boundary; clock low afterwards.
- Divisor load during RUN: div_load with div_value=8 mid-period while D=5.
  - Expected: current period stays 5 cycles; div_ack after that boundary; subsequent ticks 8 apart, clock high 4 cycles.
- Divisor error and overwrite:
  - div_value=1 → div_err pulse, divisor unchanged.
  - Two valid loads (6 then 3) in one period → single div_ack; next period length 3.
- Reset mid-period: assert reset at cnt=2 in RUN.
  - Expected: clock, tick and state go to 0/HALT immediately, without waiting for a clk edge.
  - After release: divisor=5, no stale pending load applied.
